// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   state_t : responder FSM states (IDLE, BUSY, RESP)
//   op_t    : captured operation kind (OP_READ, OP_WRITE)
//   CNT_W   : width of the wait-state counter (holds WAIT_CYCLES-1, max 14)
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int CNT_W = 4;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM, DEPTH = 2**ADDR_WIDTH words of 32 bits.
// Contents are never reset.
//   clk   : clock, write and read both on the rising edge
//   we    : write enable, stores wdata at widx
//   widx  : word index shared by write and read
//   wdata : write data
//   rdata : registered read data, mem[widx] sampled every edge (read-first)
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] widx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_r [0:DEPTH-1];
    logic [31:0] rdata_r;

    // Storage write port and registered read port on the same index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[widx] <= wdata;
        end
        rdata_r <= mem_r[widx];
    end

    assign rdata = rdata_r;

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Multi-cycle data memory answering CPU load/store requests after a fixed
// number of wait states, with a one-cycle ready pulse.
//
// Timing: a request accepted at edge N (FSM in IDLE) raises ready for the one
// cycle following edge N+WAIT_CYCLES. The FSM sits in RESP during exactly that
// cycle, so a request still held through the ready cycle is not re-accepted.
// A store commits, and a load updates Dout, at the edge that enters RESP.
//
// Parameters:
//   ADDR_WIDTH  : word-index width, depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES : edges from acceptance to ready, 1..15
// Ports:
//   clk     : clock
//   rst_n   : synchronous active-low reset (RAM contents are kept)
//   memR    : read request, held until ready
//   memW    : write request, held until ready (wins when both are high)
//   address : byte address, word index = address[ADDR_WIDTH+1:2]
//   Din     : store data
//   Dout    : load data, held until the next load completes
//   ready   : one-cycle completion pulse
//   err     : one-cycle error flag, coincident with ready
// Build option:
//   DMEM_ERR_CHECK_EN : when defined, err flags misaligned, out-of-range and
//                       read+write requests; out-of-range writes are dropped
//                       and out-of-range reads return zero. When undefined,
//                       err is constant 0 and addresses simply wrap.
// -----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memR,
    input  logic        memW,
    input  logic [31:0] address,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        ready,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t                state_r;
    op_t                   op_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [ADDR_WIDTH-1:0] widx_r;
    logic [31:0]           wdata_r;
    logic                  err_pend_r;
    logic                  kill_r;
    logic [31:0]           dout_r;
    logic                  ready_r;
    logic                  err_r;

    logic                  req_s;
    logic [ADDR_WIDTH-1:0] in_widx_s;
    logic                  err_cond_s;
    logic                  kill_s;
    logic [ADDR_WIDTH-1:0] ram_idx_s;
    logic                  finish_s;
    logic                  ram_we_s;
    logic [31:0]           ram_rdata_s;

    assign req_s     = memR | memW;
    assign in_widx_s = address[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_CHECK_EN
    logic mis_s;
    logic oor_s;
    assign mis_s      = |address[1:0];
    assign oor_s      = |address[31:ADDR_WIDTH+2];
    assign err_cond_s = mis_s | oor_s | (memR & memW);
    assign kill_s     = oor_s;
`else
    // Low and high address bits are deliberately ignored in this build.
    logic unused_addr_s;
    assign unused_addr_s = &{1'b0, address[31:ADDR_WIDTH+2], address[1:0]};
    assign err_cond_s    = 1'b0;
    assign kill_s        = 1'b0;
`endif

    // In IDLE the RAM already reads the incoming index, so a one-wait-state
    // load has valid data at the edge that enters RESP.
    assign ram_idx_s   = (state_r == IDLE) ? in_widx_s : widx_r;
    assign finish_s    = (state_r == BUSY) && (cnt_r == CNT_ZERO);
    assign ram_we_s    = finish_s && (op_r == OP_WRITE) && !kill_r;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we_s),
        .widx  (ram_idx_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Responder FSM: capture, wait-state countdown and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            op_r       <= OP_READ;
            cnt_r      <= CNT_ZERO;
            widx_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            err_pend_r <= 1'b0;
            kill_r     <= 1'b0;
            dout_r     <= 32'h0000_0000;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    if (req_s) begin
                        op_r       <= memW ? OP_WRITE : OP_READ;
                        widx_r     <= in_widx_s;
                        wdata_r    <= Din;
                        err_pend_r <= err_cond_s;
                        kill_r     <= kill_s;
                        cnt_r      <= CNT_LOAD;
                        state_r    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= RESP;
                        ready_r <= 1'b1;
                        err_r   <= err_pend_r;
                        if (op_r == OP_READ) begin
                            dout_r <= kill_r ? 32'h0000_0000 : ram_rdata_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RESP: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign Dout  = dout_r;
    assign ready = ready_r;
    assign err   = err_r;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders: u_dut0 with WAIT_CYCLES=2 and u_dut1 with WAIT_CYCLES=1.
// Expected results come from a word-array model of the memory plus the
// address/error rules; the build option DMEM_ERR_CHECK_EN selects the
// matching expectations.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic        clk;
    logic        rst_n;
    logic        r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1, err0, err1;

    int tests;
    int fails;

    // Reference state per DUT.
    logic [31:0] mem_m  [2][DEPTH];
    logic [31:0] dout_m [2];

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .memR(r0), .memW(w0), .address(a0),
        .Din(d0), .Dout(dout0), .ready(rdy0), .err(err0)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .memR(r1), .memW(w1), .address(a1),
        .Din(d1), .Dout(dout1), .ready(rdy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] din);
        if (d == 0) begin
            r0 = r; w0 = w; a0 = a; d0 = din;
        end else begin
            r1 = r; w1 = w; a1 = a; d1 = din;
        end
    endtask

    task automatic sample(input int d, output logic rv, output logic ev, output logic [31:0] dv);
        if (d == 0) begin
            rv = rdy0; ev = err0; dv = dout0;
        end else begin
            rv = rdy1; ev = err1; dv = dout1;
        end
    endtask

    // One complete CPU transaction with model update and checks.
    task automatic txn(input int d, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] din, input string tag);
        int          idx;
        bit          mis, oor, err_exp, kill;
        int          lat, lat_exp;
        logic        rv, ev, seen;
        logic [31:0] dv;

        idx     = int'((addr >> 2) % DEPTH);
        mis     = (addr % 4) != 0;
        oor     = (addr >> (AW + 2)) != 0;
`ifdef DMEM_ERR_CHECK_EN
        err_exp = mis || oor || (r && w);
        kill    = oor;
`else
        err_exp = 1'b0;
        kill    = 1'b0;
`endif
        if (w) begin
            if (!kill) mem_m[d][idx] = din;
        end else if (r) begin
            dout_m[d] = kill ? 32'h0 : mem_m[d][idx];
        end
        lat_exp = (d == 0) ? 2 : 1;

        @(negedge clk);
        drive(d, r, w, addr, din);
        @(posedge clk);               // acceptance edge
        lat  = 0;
        seen = 1'b0;
        rv   = 1'b0;
        ev   = 1'b0;
        dv   = 32'h0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            sample(d, rv, ev, dv);
            if (rv) seen = 1'b1;
        end
        check({tag, "/latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "/err"}, {31'b0, ev}, {31'b0, err_exp});
        check({tag, "/dout"}, dv, dout_m[d]);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        sample(d, rv, ev, dv);
        check({tag, "/pulse"}, {31'b0, rv}, 32'h0);
        check({tag, "/hold"}, dv, dout_m[d]);
    endtask

    initial begin
        logic        rv, ev;
        logic [31:0] dv;
        tests = 0;
        fails = 0;
        for (int d = 0; d < 2; d++) begin
            dout_m[d] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'h0;
        end
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst/ready0", {31'b0, rdy0}, 32'h0);
        check("rst/err0",   {31'b0, err0}, 32'h0);
        check("rst/dout0",  dout0,         32'h0);
        check("rst/ready1", {31'b0, rdy1}, 32'h0);
        check("rst/err1",   {31'b0, err1}, 32'h0);
        check("rst/dout1",  dout1,         32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear the words the bench reads so the model knows every value.
        for (int i = 0; i < 32; i++) begin
            txn(0, 1'b0, 1'b1, 32'(i * 4), 32'h0, "init0");
            txn(1, 1'b0, 1'b1, 32'(i * 4), 32'h0, "init1");
        end

        // Directed cases.
        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, "w10");
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0,         "r10");
        txn(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, "w20_fast");
        txn(1, 1'b1, 1'b0, 32'h20, 32'h0,         "r20_fast");
        txn(0, 1'b0, 1'b1, 32'h30, 32'h1111_1111, "w30");

        // Reset while a write is waiting in BUSY.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h30, 32'hAAAA_AAAA);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort/ready", {31'b0, rdy0}, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        dout_m[0] = 32'h0;
        dout_m[1] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            sample(0, rv, ev, dv);
            check("abort/nopulse", {31'b0, rv}, 32'h0);
        end
        check("abort/dout0", dout0, 32'h0);
        check("abort/dout1", dout1, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h30, 32'h0, "r30_after_abort");

        txn(0, 1'b1, 1'b0, 32'h13,        32'h0,         "r13_misaligned");
        txn(0, 1'b0, 1'b1, 32'h0,         32'hCAFE_F00D, "w000");
        txn(0, 1'b0, 1'b1, 32'h0000_1000, 32'h0BAD_BEEF, "w1000_oor");
        txn(0, 1'b1, 1'b0, 32'h0,         32'h0,         "r000");
        txn(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         "r1000_oor");
        txn(0, 1'b1, 1'b1, 32'h40,        32'h5,         "rw40");
        txn(0, 1'b1, 1'b0, 32'h40,        32'h0,         "r40");

        // Randomized traffic over the first 32 words, with occasional
        // misaligned and out-of-range addresses and read+write collisions.
        for (int n = 0; n < 60; n++) begin
            int          dsel, op;
            logic [31:0] addr;
            dsel = (n % 4 == 3) ? 1 : 0;
            op   = int'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 31)) * 32'd4;
            if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
            txn(dsel, (op != 2), (op >= 2), addr, $urandom, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_data_mem_responder
